// File: rtl/program_loader.sv
// program_loader: streams host words into instruction memory, starts the CPU,
// times its run and reports Done or TimedOut.
// Ports: Clock/Reset (sync, active-high); LoadValid/LoadData/LoadLast/LoadReady
// host stream; MemWrite/MemAddress/MemData registered imem write port;
// ProgramStart/End CPU start handshake; Busy, Done, TimedOut, CycleCount status.
// Option: define PROGRAM_LOADER_AUTO_HALT_EN to append a halt word (0xFC000000).
module program_loader #(
  parameter int ADDR_WIDTH  = 8,
  parameter int CYCLE_WIDTH = 16
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   LoadValid,
  input  logic [31:0]            LoadData,
  input  logic                   LoadLast,
  output logic                   LoadReady,
  output logic                   MemWrite,
  output logic [ADDR_WIDTH-1:0]  MemAddress,
  output logic [31:0]            MemData,
  output logic                   ProgramStart,
  input  logic                   End,
  output logic                   Busy,
  output logic                   Done,
  output logic                   TimedOut,
  output logic [CYCLE_WIDTH-1:0] CycleCount
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
`ifdef PROGRAM_LOADER_AUTO_HALT_EN
    S_RUN   = 3'd3,
    S_HALT  = 3'd4
`else
    S_RUN   = 3'd3
`endif
  } state_e;

`ifdef PROGRAM_LOADER_AUTO_HALT_EN
  localparam logic [31:0] HALT_WORD = 32'hFC00_0000;
`endif

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic                   we_q, we_d;
  logic [ADDR_WIDTH-1:0]  maddr_q, maddr_d;
  logic [31:0]            mdata_q, mdata_d;
  logic                   done_q, done_d;
  logic                   tout_q, tout_d;
  logic [CYCLE_WIDTH-1:0] cnt_q, cnt_d;

  logic                   xfer;
  logic [ADDR_WIDTH-1:0]  xfer_addr;
  logic                   mem_full;
  logic                   last_word;
  logic [CYCLE_WIDTH-1:0] cnt_inc;
  logic                   cnt_sat;
  state_e                 load_end;

  // State and datapath registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      wr_addr_q <= '0;
      we_q      <= 1'b0;
      maddr_q   <= '0;
      mdata_q   <= '0;
      done_q    <= 1'b0;
      tout_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      we_q      <= we_d;
      maddr_q   <= maddr_d;
      mdata_q   <= mdata_d;
      done_q    <= done_d;
      tout_q    <= tout_d;
      cnt_q     <= cnt_d;
    end
  end

  // The first word of a program always lands at address 0.
  assign xfer      = LoadValid && LoadReady;
  assign xfer_addr = (state_q == S_IDLE) ? '0 : wr_addr_q;
  assign mem_full  = &xfer_addr;
  assign last_word = LoadLast || mem_full;
  assign cnt_inc   = cnt_q + CYCLE_WIDTH'(1);
  assign cnt_sat   = &cnt_inc;

`ifdef PROGRAM_LOADER_AUTO_HALT_EN
  // No room for a halt word once the top address is written.
  assign load_end = mem_full ? S_START : S_HALT;
`else
  assign load_end = S_START;
`endif

  // Next-state and datapath next values
  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    we_d      = 1'b0;
    maddr_d   = maddr_q;
    mdata_d   = mdata_q;
    done_d    = 1'b0;
    tout_d    = tout_q;
    cnt_d     = cnt_q;

    if (xfer) begin
      we_d      = 1'b1;
      maddr_d   = xfer_addr;
      mdata_d   = LoadData;
      wr_addr_d = xfer_addr + ADDR_WIDTH'(1);
      tout_d    = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (xfer) begin
          cnt_d   = '0;
          state_d = last_word ? load_end : S_LOAD;
        end
      end
      S_LOAD: begin
        if (xfer && last_word) state_d = load_end;
      end
`ifdef PROGRAM_LOADER_AUTO_HALT_EN
      S_HALT: begin
        we_d    = 1'b1;
        maddr_d = wr_addr_q;
        mdata_d = HALT_WORD;
        state_d = S_START;
      end
`endif
      // The cycle that sees End fall is the first execution cycle.
      S_START: begin
        if (!End) begin
          cnt_d   = cnt_inc;
          tout_d  = cnt_sat;
          state_d = cnt_sat ? S_IDLE : S_RUN;
        end
      end
      S_RUN: begin
        if (End) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d   = cnt_inc;
          tout_d  = cnt_sat;
          state_d = cnt_sat ? S_IDLE : S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    LoadReady    = !Reset &&
                   ((state_q == S_IDLE) || (state_q == S_LOAD));
    ProgramStart = (state_q == S_START);
    Busy         = (state_q != S_IDLE);
  end

  assign MemWrite   = we_q;
  assign MemAddress = maddr_q;
  assign MemData    = mdata_q;
  assign Done       = done_q;
  assign TimedOut   = tout_q;
  assign CycleCount = cnt_q;

endmodule
